status_register_unit: RTL
=========================

Name: status_register_unit

Overview:
- Producer side of the NZCV status interface.
- Computes N, Z, C, V from the execute-stage ALU operation and opcode, holds them in a one-entry pending stage, then commits them to the architectural STATUS register.
- STATUS feeds the condition checker in decode as the 4-bit bundle {N,Z,C,V}.
- Also provides a forwarded status, a busy flag for the hazard unit, and a direct flag-write path.

Parameters:
WIDTH, 32, ALU datapath width in bits (minimum 2).

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST_N  input  1  asynchronous, active-low reset.
EXE_CMD  input  4  ALU opcode: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000; any other value is a no-op.
ALU_A  input  WIDTH  first operand (Rn).
ALU_B  input  WIDTH  second operand (shifter output).
SHIFT_CARRY  input  1  shifter carry-out, used for logical ops.
S_EN  input  1  instruction in EXE has S bit set and is valid.
STALL  input  1  freeze the pending stage and STATUS.
FLUSH  input  1  discard the pending entry; suppress the capture this cycle.
WR_EN  input  1  direct flag write (MSR-flags).
WR_DATA  input  4  {N,Z,C,V} for the direct write.
ALU_RESULT  output  WIDTH  combinational ALU result.
STATUS  output  4  committed {N,Z,C,V}.
STATUS_FWD  output  4  pending flags if the pending entry is valid, else STATUS.
FLAGS_BUSY  output  1  pending entry is valid.

Behaviour:
- Reset (RST_N=0, asynchronous): STATUS=0000, pending valid=0, pending flags=0000, FLAGS_BUSY=0. Reset mid-operation discards everything. The first capture happens on the first edge after deassertion.
- Arithmetic: compute on WIDTH+1 bits. Cin is STATUS[1] (committed C, not forwarded).
  - ADD: R = A+B. C = bit WIDTH.
  - ADC: R = A+B+Cin.
  - SUB: R = A+~B+1. C = 1 when no borrow (A >= B unsigned).
  - SBC: R = A+~B+Cin.
  - V for ADD/ADC: A[msb]==B[msb] && R[msb]!=A[msb].
  - V for SUB/SBC: A[msb]!=B[msb] && R[msb]!=A[msb].
- Logical ops:
  - MOV: R=B. MVN: R=~B. AND/ORR/EOR: bitwise.
  - C = SHIFT_CARRY. V = unchanged (current STATUS[0]).
- No-op opcode: R=0. Flags are not captured even if S_EN=1.
- Flags for all captured ops: N = R[WIDTH-1]; Z = (R==0).
- Pending stage, evaluated each edge in priority order:
  - FLUSH=1: pending valid <= 0; no capture. If the pending entry was valid, it is dropped and not committed.
  - STALL=1: pending entry and STATUS hold.
  - Otherwise:
    - If pending valid, STATUS <= pending flags (commit).
    - Then pending valid <= S_EN && op valid, and pending flags <= new flags.
- Latency: flags are captured at edge k and appear in STATUS after edge k+1. STATUS_FWD shows them from edge k.
- Back-to-back S instructions: the older entry commits in the same edge the newer one is captured. No loss.
- WR_EN, the direct write:
  - Takes effect on any edge where RST_N=1, including under STALL or FLUSH.
  - STATUS <= WR_DATA. Pending valid <= 0, overriding both commit and capture.
  - WR_EN and S_EN in the same cycle: the write wins; the S capture is dropped.
- FLUSH and STALL together: FLUSH wins.
- FLAGS_BUSY equals pending valid. It is used by the hazard unit when forwarding is disabled.
- Wrap-around: 0xFFFFFFFF+1 gives R=0 with Z=1, C=1, V=0. SUB 0-1 gives R=0xFFFFFFFF with N=1, C=0, V=0.

Test Plan:
1. Reset then ADD, S_EN=1, A=0x7FFFFFFF, B=1 -> STATUS_FWD=1001 after edge 1; STATUS=1001 after edge 2; FLAGS_BUSY 1 for exactly one cycle.
2. SUB (CMP), S_EN=1, A=5, B=5, then 0 then 6 on consecutive cycles -> STATUS sequence 0110, 0010, 1000; no cycle skipped.
3. AND with SHIFT_CARRY=1, S_EN=1 after STATUS=0001 -> STATUS=0011 with V preserved. Same op with S_EN=0 -> STATUS unchanged.
4. ADD captured, then FLUSH=1 next cycle -> STATUS keeps its old value; FLAGS_BUSY drops to 0.
5. STALL=1 for 3 cycles with the pending entry valid -> STATUS and STATUS_FWD hold; commit on the first unstalled edge. WR_EN=1 with WR_DATA=1010 during the stall -> STATUS=1010, pending cleared.
6. ADC with STATUS C=1, A=0xFFFFFFFF, B=0 -> R=0, flags 0110. RST_N pulsed low mid-stream -> STATUS=0000 immediately (asynchronous).

Source files
------------

// File: rtl/status_register_unit.sv
// NZCV producer: execute-stage ALU with flag generation, a one-entry pending
// flag stage, the architectural STATUS register and a direct flag-write path.
module status_register_unit #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [3:0]       EXE_CMD,
   input  logic [WIDTH-1:0] ALU_A,
   input  logic [WIDTH-1:0] ALU_B,
   input  logic             SHIFT_CARRY,
   input  logic             S_EN,
   input  logic             STALL,
   input  logic             FLUSH,
   input  logic             WR_EN,
   input  logic [3:0]       WR_DATA,
   output logic [WIDTH-1:0] ALU_RESULT,
   output logic [3:0]       STATUS,
   output logic [3:0]       STATUS_FWD,
   output logic             FLAGS_BUSY
);

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_MVN = 4'b1001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;

   localparam int MSB = WIDTH - 1;

   logic [3:0]       status_q, status_d;
   logic [3:0]       pend_flags_q, pend_flags_d;
   logic             pend_vld_q, pend_vld_d;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   cin_ext;
   logic [WIDTH-1:0] res;
   logic             c_flag, v_flag, op_valid;
   logic [3:0]       new_flags;

   // Carry-in always comes from the committed C, never the forwarded one.
   assign cin_ext = (WIDTH+1)'(status_q[1]);

   always_comb begin
      sum      = '0;
      res      = '0;
      c_flag   = SHIFT_CARRY;
      v_flag   = status_q[0];
      op_valid = 1'b1;
      case (EXE_CMD)
         OP_MOV: res = ALU_B;
         OP_MVN: res = ~ALU_B;
         OP_AND: res = ALU_A & ALU_B;
         OP_ORR: res = ALU_A | ALU_B;
         OP_EOR: res = ALU_A ^ ALU_B;
         OP_ADD, OP_ADC: begin
            sum    = {1'b0, ALU_A} + {1'b0, ALU_B}
                     + ((EXE_CMD == OP_ADC) ? cin_ext : '0);
            res    = sum[WIDTH-1:0];
            c_flag = sum[WIDTH];
            v_flag = (ALU_A[MSB] == ALU_B[MSB]) && (res[MSB] != ALU_A[MSB]);
         end
         OP_SUB, OP_SBC: begin
            sum    = {1'b0, ALU_A} + {1'b0, ~ALU_B}
                     + ((EXE_CMD == OP_SBC) ? cin_ext : (WIDTH+1)'(1));
            res    = sum[WIDTH-1:0];
            c_flag = sum[WIDTH];
            v_flag = (ALU_A[MSB] != ALU_B[MSB]) && (res[MSB] != ALU_A[MSB]);
         end
         default: begin
            op_valid = 1'b0;
            c_flag   = status_q[1];
         end
      endcase
      new_flags = {res[MSB], (res == '0), c_flag, v_flag};
   end

   // Direct write beats flush, flush beats stall, otherwise commit-then-capture.
   always_comb begin
      status_d     = status_q;
      pend_vld_d   = pend_vld_q;
      pend_flags_d = pend_flags_q;
      if (WR_EN) begin
         status_d   = WR_DATA;
         pend_vld_d = 1'b0;
      end else if (FLUSH) begin
         pend_vld_d = 1'b0;
      end else if (!STALL) begin
         if (pend_vld_q) status_d = pend_flags_q;
         pend_vld_d   = S_EN && op_valid;
         pend_flags_d = new_flags;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         status_q     <= 4'b0000;
         pend_vld_q   <= 1'b0;
         pend_flags_q <= 4'b0000;
      end else begin
         status_q     <= status_d;
         pend_vld_q   <= pend_vld_d;
         pend_flags_q <= pend_flags_d;
      end
   end

   assign ALU_RESULT = res;
   assign STATUS     = status_q;
   assign STATUS_FWD = pend_vld_q ? pend_flags_q : status_q;
   assign FLAGS_BUSY = pend_vld_q;

endmodule
